// File: rtl/lvt_multiport_ram.sv
// Multi-ported RAM with write_ports writers and read_ports readers on one clock.
// Each (write, read) port pair has its own 1W1R bank; a live-value table steers each read.
module lvt_multiport_ram #(
  parameter int value_width = 32,
  parameter int index_width = 8,
  parameter int write_ports = 2,
  parameter int read_ports  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [write_ports-1:0]            wr_en,
  input  logic [write_ports*index_width-1:0] wr_addr,
  input  logic [write_ports*value_width-1:0] wr_data,
  input  logic [read_ports-1:0]             rd_en,
  input  logic [read_ports*index_width-1:0] rd_addr,
  output logic [read_ports*value_width-1:0] rd_data,
  output logic [read_ports-1:0]             rd_valid
);

  localparam int depth = 2 ** index_width;
  localparam int lvt_w = (write_ports > 1) ? $clog2(write_ports) : 1;

  logic [value_width-1:0] mem    [write_ports][read_ports][depth];
  logic [value_width-1:0] bank_q [read_ports][write_ports];
  logic [lvt_w-1:0]       lvt    [depth];
  logic [lvt_w-1:0]       lvt_sel [read_ports];
  logic [read_ports-1:0]  has_read;

  // Banks carry no reset so they map onto plain RAM; the read register is read-first.
  always_ff @(posedge clk) begin
    for (int p = 0; p < write_ports; p++) begin
      for (int r = 0; r < read_ports; r++) begin
        if (wr_en[p])
          mem[p][r][wr_addr[p*index_width +: index_width]] <= wr_data[p*value_width +: value_width];
        if (rd_en[r])
          bank_q[r][p] <= mem[p][r][rd_addr[r*index_width +: index_width]];
      end
    end
  end

  // Descending scan so the lowest-numbered port lands last and wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++)
        lvt[i] <= '0;
    end else begin
      for (int p = write_ports - 1; p >= 0; p--)
        if (wr_en[p])
          lvt[wr_addr[p*index_width +: index_width]] <= lvt_w'(p);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= '0;
      has_read <= '0;
      for (int r = 0; r < read_ports; r++)
        lvt_sel[r] <= '0;
    end else begin
      rd_valid <= rd_en;
      has_read <= has_read | rd_en;
      for (int r = 0; r < read_ports; r++)
        if (rd_en[r])
          lvt_sel[r] <= lvt[rd_addr[r*index_width +: index_width]];
    end
  end

  // has_read masks the unreset bank registers so outputs read 0 straight out of reset.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < read_ports; r++)
      if (has_read[r])
        rd_data[r*value_width +: value_width] = bank_q[r][lvt_sel[r]];
  end

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed bench for lvt_multiport_ram with two write and two read ports.
module tb_lvt_multiport_ram;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;

  int checks;
  int failures;

  lvt_multiport_ram #(
    .value_width(32), .index_width(8), .write_ports(2), .read_ports(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00;
    rd_en = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); wr_addr = '0; wr_data = '0; rd_addr = '0;
    #3;
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    checks++;
    if (rd_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", rd_valid); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL post_reset_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_basic();
    wr_en = 2'b01; wr_addr[7:0] = 8'h10; wr_data[31:0] = 32'hDEADBEEF;
    tick(); idle();
    rd_en = 2'b01; rd_addr[7:0] = 8'h10;
    tick(); idle();
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got=%h exp=deadbeef", rd_data[31:0]); end
    checks++;
    if (rd_valid !== 2'b01) begin failures++; $display("FAIL basic_valid got=%b exp=01", rd_valid); end
    tick();
    checks++;
    if (rd_valid !== 2'b00) begin failures++; $display("FAIL basic_valid_drop got=%b exp=00", rd_valid); end
  endtask

  task automatic test_cross_port();
    wr_en = 2'b11;
    wr_addr = {8'h20, 8'h21}; wr_data = {32'h12345678, 32'hA5A5A5A5};
    tick(); idle();
    rd_en = 2'b11; rd_addr = {8'h21, 8'h20};
    tick();
    checks++;
    if (rd_data !== {32'hA5A5A5A5, 32'h12345678}) begin failures++; $display("FAIL cross_a got=%h exp=a5a5a5a5_12345678", rd_data); end
    rd_addr = {8'h20, 8'h21};
    tick(); idle();
    checks++;
    if (rd_data !== {32'h12345678, 32'hA5A5A5A5}) begin failures++; $display("FAIL cross_b got=%h exp=12345678_a5a5a5a5", rd_data); end
    checks++;
    if (rd_valid !== 2'b11) begin failures++; $display("FAIL cross_valid got=%b exp=11", rd_valid); end
    wr_en = 2'b01; wr_addr[7:0] = 8'h20; wr_data[31:0] = 32'h1;
    tick(); idle();
    rd_en = 2'b11; rd_addr = {8'h20, 8'h20};
    tick(); idle();
    checks++;
    if (rd_data !== {32'h1, 32'h1}) begin failures++; $display("FAIL cross_overwrite got=%h exp=1_1", rd_data); end
  endtask

  task automatic test_collision();
    wr_en = 2'b11; wr_addr = {8'h05, 8'h05}; wr_data = {32'h22, 32'h11};
    tick(); idle();
    rd_en = 2'b11; rd_addr = {8'h05, 8'h05};
    tick(); idle();
    checks++;
    if (rd_data !== {32'h11, 32'h11}) begin failures++; $display("FAIL collision got=%h exp=11_11", rd_data); end
  endtask

  task automatic test_read_during_write();
    wr_en = 2'b01; wr_addr[7:0] = 8'h30; wr_data[31:0] = 32'h7;
    tick(); idle();
    wr_en = 2'b10; wr_addr[15:8] = 8'h30; wr_data[63:32] = 32'h9;
    rd_en = 2'b10; rd_addr[15:8] = 8'h30;
    tick(); idle();
    checks++;
    if (rd_data[63:32] !== 32'h7) begin failures++; $display("FAIL rdw_old got=%h exp=7", rd_data[63:32]); end
    rd_en = 2'b11; rd_addr = {8'h30, 8'h30};
    tick(); idle();
    checks++;
    if (rd_data !== {32'h9, 32'h9}) begin failures++; $display("FAIL rdw_new got=%h exp=9_9", rd_data); end
  endtask

  task automatic test_hold();
    wr_en = 2'b10; wr_addr[15:8] = 8'h60; wr_data[63:32] = 32'h55;
    tick(); idle();
    rd_en = 2'b01; rd_addr[7:0] = 8'h60;
    tick(); idle();
    checks++;
    if (rd_data[31:0] !== 32'h55 || rd_valid[0] !== 1'b1) begin
      failures++; $display("FAIL hold_first got=%h/%b exp=55/1", rd_data[31:0], rd_valid[0]);
    end
    rd_addr = {8'h10, 8'h10};
    wr_en = 2'b10; wr_addr[15:8] = 8'h60; wr_data[63:32] = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
      checks++;
      if (rd_data[31:0] !== 32'h55 || rd_valid !== 2'b00) begin
        failures++; $display("FAIL hold_cycle%0d got=%h/%b exp=55/00", i, rd_data[31:0], rd_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 2'b01; wr_addr[7:0] = 8'h70; wr_data[31:0] = 32'hAAAA;
    tick();
    wr_en = 2'b10; wr_addr[15:8] = 8'h70; wr_data[63:32] = 32'hBBBB;
    tick(); idle();
    rd_en = 2'b01; rd_addr[7:0] = 8'h70;
    tick();
    checks++;
    if (rd_data[31:0] !== 32'hBBBB) begin failures++; $display("FAIL pre_reset got=%h exp=bbbb", rd_data[31:0]); end
    rd_en = 2'b11; rd_addr = {8'h70, 8'h70};
    @(posedge clk); idle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data !== 64'h0 || rd_valid !== 2'b00) begin
      failures++; $display("FAIL reset_immediate got=%h/%b exp=0/00", rd_data, rd_valid);
    end
    tick();
    checks++;
    if (rd_data !== 64'h0 || rd_valid !== 2'b00) begin
      failures++; $display("FAIL reset_held got=%h/%b exp=0/00", rd_data, rd_valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 2'b00) begin failures++; $display("FAIL reset_inflight got=%b exp=00", rd_valid); end
    rd_en = 2'b01; rd_addr[7:0] = 8'h70;
    tick(); idle();
    checks++;
    if (rd_data[31:0] !== 32'hAAAA) begin failures++; $display("FAIL lvt_cleared got=%h exp=aaaa", rd_data[31:0]); end
    wr_en = 2'b10; wr_addr[15:8] = 8'h40; wr_data[63:32] = 32'hCAFE;
    tick(); idle();
    rd_en = 2'b11; rd_addr = {8'h40, 8'h40};
    tick(); idle();
    checks++;
    if (rd_data !== {32'hCAFE, 32'hCAFE} || rd_valid !== 2'b11) begin
      failures++; $display("FAIL post_reset_write got=%h/%b exp=cafe_cafe/11", rd_data, rd_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_cross_port();
    test_collision();
    test_read_during_write();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
